// File: rtl/rho_inv_serial.sv
// rho_inv_serial: lane-serial inverse-rho unit for the Keccak state.
// Each cycle in BUSY, LANES_PER_CYCLE lanes of the working register are
// rotated right by their fixed rho offset. The lanes are processed in
// ascending order l = 5*x + y. The finished state is then presented on
// the output handshake.
// Optional macro KECCAK_RHO_FWD_EN adds a 'mode' input that selects the
// forward rotation (rotl). This input is sampled with the input handshake.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE. out_valid is high only in DONE. While
// out_valid is high, state_out is held stable until out_ready accepts it.

package keccak_pkg;
  localparam int ROW_SIZE  = 5;
  localparam int COL_SIZE  = 5;
  localparam int LANE_SIZE = 64;
endpackage

module rho_inv_serial
  import keccak_pkg::*;
#(
  parameter int LANES_PER_CYCLE = 5
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]   state_in,
`ifdef KECCAK_RHO_FWD_EN
  input  logic                                               mode,
`endif
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]   state_out,
  output logic                                               busy,
  output logic [1:0]                                         state_dbg
);

  localparam int NLANES = ROW_SIZE * COL_SIZE;
  localparam int NCYC   = NLANES / LANES_PER_CYCLE;
  localparam int CNT_W  = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (!(LANES_PER_CYCLE == 1 || LANES_PER_CYCLE == 5 || LANES_PER_CYCLE == 25)) begin : g_bad_lpc
    $error("rho_inv_serial: LANES_PER_CYCLE must be 1, 5 or 25");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                                  state_q, state_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic [NLANES-1:0][LANE_SIZE-1:0]        work_q, work_d;
`ifdef KECCAK_RHO_FWD_EN
  logic                                    mode_q, mode_d;
`endif

  // The rho offset for flat lane index l = 5*x + y.
  function automatic logic [5:0] off_of(input logic [4:0] l);
    logic [5:0] o;
    case (l)
      5'd0:  o = 6'd0;   5'd1:  o = 6'd36;  5'd2:  o = 6'd3;
      5'd3:  o = 6'd41;  5'd4:  o = 6'd18;  5'd5:  o = 6'd1;
      5'd6:  o = 6'd44;  5'd7:  o = 6'd10;  5'd8:  o = 6'd45;
      5'd9:  o = 6'd2;   5'd10: o = 6'd62;  5'd11: o = 6'd6;
      5'd12: o = 6'd43;  5'd13: o = 6'd15;  5'd14: o = 6'd61;
      5'd15: o = 6'd28;  5'd16: o = 6'd55;  5'd17: o = 6'd25;
      5'd18: o = 6'd21;  5'd19: o = 6'd56;  5'd20: o = 6'd27;
      5'd21: o = 6'd20;  5'd22: o = 6'd39;  5'd23: o = 6'd8;
      5'd24: o = 6'd14;
      default: o = 6'd0;
    endcase
    return o;
  endfunction

  // The rotation is done on a doubled word. Because of this, an offset of
  // 0 needs no special case.
  function automatic logic [LANE_SIZE-1:0] rotr(input logic [LANE_SIZE-1:0] v,
                                                input logic [5:0] s);
    logic [2*LANE_SIZE-1:0] t;
    t = {v, v} >> s;
    return t[LANE_SIZE-1:0];
  endfunction

`ifdef KECCAK_RHO_FWD_EN
  function automatic logic [LANE_SIZE-1:0] rotl(input logic [LANE_SIZE-1:0] v,
                                                input logic [5:0] s);
    logic [2*LANE_SIZE-1:0] t;
    t = {v, v} << s;
    return t[2*LANE_SIZE-1:LANE_SIZE];
  endfunction
`endif

  // This returns the lane handled by slot j when the lane counter is c.
  function automatic logic [4:0] lane_of(input logic [CNT_W-1:0] c, input int j);
    return 5'(int'(c) * LANES_PER_CYCLE + j);
  endfunction

  // This process holds the next-state logic and the in-place lane rotation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
`ifdef KECCAK_RHO_FWD_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          cnt_d   = '0;
`ifdef KECCAK_RHO_FWD_EN
          mode_d  = mode;
`endif
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int j = 0; j < LANES_PER_CYCLE; j++) begin
`ifdef KECCAK_RHO_FWD_EN
          work_d[lane_of(cnt_q, j)] = mode_q
            ? rotl(work_q[lane_of(cnt_q, j)], off_of(lane_of(cnt_q, j)))
            : rotr(work_q[lane_of(cnt_q, j)], off_of(lane_of(cnt_q, j)));
`else
          work_d[lane_of(cnt_q, j)] =
            rotr(work_q[lane_of(cnt_q, j)], off_of(lane_of(cnt_q, j)));
`endif
        end
        if (cnt_q == CNT_W'(NCYC - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // This process holds the state, the counter and the working register.
  // A reset aborts any operation that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
`ifdef KECCAK_RHO_FWD_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
`ifdef KECCAK_RHO_FWD_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);
  assign state_out = work_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rho_inv_serial.sv
// tb_rho_inv_serial: bench for rho_inv_serial with three instances
// (LANES_PER_CYCLE = 1, 5 and 25). They share the same clock and reset.
// Expected states come from a bit-level rho model that is kept here.
module tb_rho_inv_serial;

  typedef logic [4:0][4:0][63:0] state_t;

  localparam int OFF [5][5] = '{
    '{ 0, 36,  3, 41, 18},
    '{ 1, 44, 10, 45,  2},
    '{62,  6, 43, 15, 61},
    '{28, 55, 25, 21, 56},
    '{27, 20, 39,  8, 14}
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid  [3];
  logic       in_ready  [3];
  state_t     st_in     [3];
  logic       out_valid [3];
  logic       out_ready [3];
  state_t     st_out    [3];
  logic       busy      [3];
  logic [1:0] dbg       [3];
`ifdef KECCAK_RHO_FWD_EN
  logic       mode_drv  [3];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rho_inv_serial #(.LANES_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 5 : 25))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .state_in  (st_in[g]),
`ifdef KECCAK_RHO_FWD_EN
      .mode      (mode_drv[g]),
`endif
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .state_out (st_out[g]),
      .busy      (busy[g]),
      .state_dbg (dbg[g])
    );
  end

  function automatic int ncyc_of(input int d);
    return (d == 0) ? 25 : ((d == 1) ? 5 : 1);
  endfunction

  // Reference model: output bit i of a lane takes input bit (i + off) mod 64
  // for the right rotation, and bit (i - off) mod 64 for the left rotation.
  function automatic state_t ref_rho(input state_t s, input bit fwd);
    state_t r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int i = 0; i < 64; i++)
          r[x][y][i] = fwd ? s[x][y][(i + 64 - OFF[x][y]) % 64]
                           : s[x][y][(i + OFF[x][y]) % 64];
    return r;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = {$urandom, $urandom};
    return s;
  endfunction

  // This returns the first lane (5*x+y) where a and b differ. It is used
  // only so that a failure can be reported on a short line.
  function automatic int diff_lane(input state_t a, input state_t b);
    for (int l = 0; l < 25; l++)
      if (a[l/5][l%5] !== b[l/5][l%5]) return l;
    return 0;
  endfunction

  // This drives one state into instance d and waits for the result.
  // lat is the number of edges after the accept edge at which out_valid is
  // first observed. ok is 0 if a bound ran out.
  task automatic run_op(input int d, input state_t s,
                        output state_t got, output int lat, output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    st_in[d]    = s;
    in_valid[d] = 1'b1;
    n = 0;
    while (in_ready[d] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) ok = 1'b0;
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    lat = 0;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid[d] === 1'b1) break;
      n++;
    end
    if (n >= 100) ok = 1'b0;
    got = st_out[d];
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1 out_ready[d] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1) begin
        errors++; $display("FAIL reset_in_ready d=%0d got=%b exp=1", d, in_ready[d]);
      end
      checks++;
      if (out_valid[d] !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid d=%0d got=%b exp=0", d, out_valid[d]);
      end
      checks++;
      if (busy[d] !== 1'b0) begin
        errors++; $display("FAIL reset_busy d=%0d got=%b exp=0", d, busy[d]);
      end
      checks++;
      if (dbg[d] !== 2'd0) begin
        errors++; $display("FAIL reset_state d=%0d got=%0d exp=0", d, dbg[d]);
      end
      checks++;
      if (st_out[d] !== '0) begin
        errors++;
        $display("FAIL reset_state_out d=%0d lane %0d got=%h exp=0", d,
                 diff_lane(st_out[d], '0), st_out[d][diff_lane(st_out[d], '0) / 5][diff_lane(st_out[d], '0) % 5]);
      end
    end
  endtask

  task automatic test_single_bit;
    state_t s, got;
    int lat;
    bit ok;
    s = '0;
    s[0][1] = 64'h1;
    run_op(1, s, got, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_bit_timeout got=timeout exp=done"); end
    checks++;
    if (got[0][1] !== 64'h0000_0000_1000_0000) begin
      errors++; $display("FAIL single_bit_lane01 got=%h exp=%h", got[0][1], 64'h0000_0000_1000_0000);
    end
    checks++;
    got[0][1] = '0;
    if (got !== '0) begin
      errors++; $display("FAIL single_bit_others lane %0d got nonzero exp=0", diff_lane(got, '0));
    end
    // out_valid is first seen by the 6th edge after accept.
    checks++;
    if (lat + 1 !== 6) begin
      errors++; $display("FAIL single_bit_latency got=%0d exp=6", lat + 1);
    end
  endtask

  task automatic test_two_lanes;
    state_t s, got;
    int lat;
    bit ok;
    s = '0;
    s[2][0] = 64'h1;
    s[0][0] = 64'hDEAD_BEEF_0123_4567;
    run_op(1, s, got, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL two_lanes_timeout got=timeout exp=done"); end
    checks++;
    if (got[2][0] !== 64'h4) begin
      errors++; $display("FAIL two_lanes_20 got=%h exp=%h", got[2][0], 64'h4);
    end
    checks++;
    if (got[0][0] !== 64'hDEAD_BEEF_0123_4567) begin
      errors++; $display("FAIL two_lanes_00 got=%h exp=%h", got[0][0], 64'hDEAD_BEEF_0123_4567);
    end
  endtask

  task automatic test_random_lpc;
    state_t s, exp_s, got;
    int lat, l;
    bit ok;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 4; k++) begin
        s = rand_state();
        exp_s = ref_rho(s, 1'b0);
        run_op(d, s, got, lat, ok);
        checks++;
        if (!ok || got !== exp_s) begin
          errors++;
          l = diff_lane(got, exp_s);
          $display("FAIL random d=%0d k=%0d lane %0d got=%h exp=%h ok=%0d",
                   d, k, l, got[l/5][l%5], exp_s[l/5][l%5], ok);
        end
        checks++;
        if (lat + 1 !== ncyc_of(d) + 1) begin
          errors++; $display("FAIL latency d=%0d got=%0d exp=%0d", d, lat + 1, ncyc_of(d) + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    state_t s1, s2, e1, e2, got;
    int n, l;
    s1 = rand_state();
    s2 = rand_state();
    e1 = ref_rho(s1, 1'b0);
    e2 = ref_rho(s2, 1'b0);
    @(negedge clk);
    st_in[1] = s1; in_valid[1] = 1'b1; out_ready[1] = 1'b0;
    @(posedge clk);
    #1 in_valid[1] = 1'b0;
    n = 0;
    @(negedge clk);
    while (out_valid[1] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL bp_wait got=timeout exp=out_valid"); end
    for (int i = 0; i < 10; i++) begin
      st_in[1] = s2;
      in_valid[1] = i[0];
      @(negedge clk);
      checks++;
      if (st_out[1] !== e1 || in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1) begin
        errors++;
        l = diff_lane(st_out[1], e1);
        $display("FAIL bp_hold i=%0d lane %0d got=%h exp=%h in_ready=%b out_valid=%b",
                 i, l, st_out[1][l/5][l%5], e1[l/5][l%5], in_ready[1], out_valid[1]);
      end
    end
    in_valid[1] = 1'b1;
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1 out_ready[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
      errors++; $display("FAIL bp_idle got in_ready=%b out_valid=%b exp 1/0", in_ready[1], out_valid[1]);
    end
    @(posedge clk);
    #1 in_valid[1] = 1'b0;
    n = 0;
    @(negedge clk);
    while (out_valid[1] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    got = st_out[1];
    checks++;
    if (n >= 100 || got !== e2) begin
      errors++;
      l = diff_lane(got, e2);
      $display("FAIL bp_second lane %0d got=%h exp=%h", l, got[l/5][l%5], e2[l/5][l%5]);
    end
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1 out_ready[1] = 1'b0;
  endtask

  task automatic test_reset_mid;
    state_t s, got, exp_s;
    int lat, l;
    bit ok;
    s = rand_state();
    @(negedge clk);
    st_in[1] = s; in_valid[1] = 1'b1;
    @(posedge clk);
    #1 in_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (busy[1] !== 1'b1) begin
      errors++; $display("FAIL mid_busy_before got=%b exp=1", busy[1]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
      errors++; $display("FAIL mid_reset got out_valid=%b in_ready=%b busy=%b exp 0/1/0",
                         out_valid[1], in_ready[1], busy[1]);
    end
    checks++;
    if (st_out[1] !== '0) begin
      errors++; $display("FAIL mid_reset_state_out lane %0d got nonzero exp=0", diff_lane(st_out[1], '0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    s = rand_state();
    exp_s = ref_rho(s, 1'b0);
    run_op(1, s, got, lat, ok);
    checks++;
    if (!ok || got !== exp_s) begin
      errors++;
      l = diff_lane(got, exp_s);
      $display("FAIL mid_fresh lane %0d got=%h exp=%h ok=%0d", l, got[l/5][l%5], exp_s[l/5][l%5], ok);
    end
  endtask

`ifdef KECCAK_RHO_FWD_EN
  task automatic test_fwd;
    state_t s, f, b, got;
    int lat, l;
    bit ok;
    s = rand_state();
    mode_drv[1] = 1'b1;
    run_op(1, s, f, lat, ok);
    checks++;
    if (!ok || f !== ref_rho(s, 1'b1)) begin
      errors++; l = diff_lane(f, ref_rho(s, 1'b1));
      $display("FAIL fwd_random lane %0d got=%h ok=%0d", l, f[l/5][l%5], ok);
    end
    mode_drv[1] = 1'b0;
    run_op(1, f, b, lat, ok);
    checks++;
    if (!ok || b !== s) begin
      errors++; l = diff_lane(b, s);
      $display("FAIL fwd_roundtrip lane %0d got=%h exp=%h", l, b[l/5][l%5], s[l/5][l%5]);
    end
    s = '0;
    s[0][1] = 64'h1;
    mode_drv[1] = 1'b1;
    run_op(1, s, got, lat, ok);
    mode_drv[1] = 1'b0;
    checks++;
    if (got[0][1] !== 64'h0000_0010_0000_0000) begin
      errors++; $display("FAIL fwd_single got=%h exp=%h", got[0][1], 64'h0000_0010_0000_0000);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      st_in[d]     = '0;
`ifdef KECCAK_RHO_FWD_EN
      mode_drv[d]  = 1'b0;
`endif
    end
    test_reset();
    test_single_bit();
    test_two_lanes();
    test_random_lpc();
    test_backpressure();
    test_reset_mid();
`ifdef KECCAK_RHO_FWD_EN
    test_fwd();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
